// File: rtl/pipe_wb_multi.sv
// Multi-issue writeback buffer: queues EX results, commits up to NUM_WP per cycle in order,
// forwards buffered results, and halts with a full flush when an ebreak retires.
module pipe_wb_multi #(
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned NUM_WP = 2,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned XLEN   = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_IN-1:0]                in_valid_i,
  output logic                             in_ready_o,
  input  logic [NUM_IN-1:0][XLEN-1:0]      in_pc_i,
  input  logic [NUM_IN-1:0][31:0]          in_inst_i,
  input  logic [NUM_IN-1:0]                in_rd_wen_i,
  input  logic [NUM_IN-1:0][4:0]           in_rd_i,
  input  logic [NUM_IN-1:0]                in_is_load_i,
  input  logic [NUM_IN-1:0][XLEN-1:0]      in_alu_res_i,
  input  logic [NUM_IN-1:0][XLEN-1:0]      in_lsu_res_i,
  input  logic [NUM_IN-1:0]                in_ebreak_i,
  output logic [NUM_WP-1:0]                wb_wen_o,
  output logic [NUM_WP-1:0][4:0]           wb_rd_o,
  output logic [NUM_WP-1:0][XLEN-1:0]      wb_wdata_o,
  output logic [NUM_WP-1:0]                commit_valid_o,
  output logic [NUM_WP-1:0][XLEN-1:0]      commit_pc_o,
  output logic [NUM_WP-1:0][31:0]          commit_inst_o,
  input  logic [1:0][4:0]                  fwd_rd_i,
  output logic [1:0]                       fwd_hit_o,
  output logic [1:0][XLEN-1:0]             fwd_data_o,
  output logic                             halted_o,
  output logic [$clog2(DEPTH):0]           occupancy_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            rd_wen;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            ebreak;
  } entry_t;

  entry_t                  mem_q [DEPTH];
  entry_t [NUM_IN-1:0]     lane_ent;
  logic [PtrW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]         occ_q, occ_d, push_cnt, pop_cnt;
  logic                    halted_q, halted_d;
  logic                    push, flush;

  // Readiness uses current occupancy only, so a full-width bundle always fits.
  always_comb begin
    in_ready_o = rst_i && !halted_q && (occ_q <= CntW'(DEPTH - NUM_IN));
    push       = in_ready_o && in_valid_i[0];
    push_cnt   = '0;
    for (int k = 0; k < int'(NUM_IN); k++) begin
      if (in_valid_i[k]) push_cnt = push_cnt + CntW'(1);
      lane_ent[k].pc     = in_pc_i[k];
      lane_ent[k].inst   = in_inst_i[k];
      lane_ent[k].rd_wen = in_rd_wen_i[k];
      lane_ent[k].rd     = in_rd_i[k];
      lane_ent[k].data   = in_is_load_i[k] ? in_lsu_res_i[k] : in_alu_res_i[k];
      lane_ent[k].ebreak = in_ebreak_i[k];
    end
  end

  // Oldest entries go out on the lowest ports; an ebreak masks every younger port.
  always_comb begin
    entry_t e;
    logic   stop;
    stop    = 1'b0;
    flush   = 1'b0;
    pop_cnt = '0;
    for (int j = 0; j < int'(NUM_WP); j++) begin
      e                 = mem_q[head_q + PtrW'(j)];
      commit_pc_o[j]    = e.pc;
      commit_inst_o[j]  = e.inst;
      wb_rd_o[j]        = e.rd;
      wb_wdata_o[j]     = e.data;
      commit_valid_o[j] = rst_i && !halted_q && !stop && (CntW'(j) < occ_q);
      wb_wen_o[j]       = commit_valid_o[j] && e.rd_wen && (e.rd != 5'd0);
      if (commit_valid_o[j]) begin
        pop_cnt = pop_cnt + CntW'(1);
        if (e.ebreak) begin
          stop  = 1'b1;
          flush = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (flush) begin
      head_d   = tail_q;
      tail_d   = tail_q;
      occ_d    = '0;
      halted_d = 1'b1;
    end else begin
      head_d   = head_q + PtrW'(pop_cnt);
      tail_d   = push ? tail_q + PtrW'(push_cnt) : tail_q;
      occ_d    = occ_q + (push ? push_cnt : '0) - pop_cnt;
      halted_d = halted_q;
    end
  end

  // Scan oldest to youngest so the last match wins; entries retiring this cycle still count.
  always_comb begin
    entry_t e;
    for (int p = 0; p < 2; p++) begin
      fwd_hit_o[p]  = 1'b0;
      fwd_data_o[p] = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        e = mem_q[head_q + PtrW'(i)];
        if (rst_i && (CntW'(i) < occ_q) && e.rd_wen && (e.rd == fwd_rd_i[p]) &&
            (e.rd != 5'd0)) begin
          fwd_hit_o[p]  = 1'b1;
          fwd_data_o[p] = e.data;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      occ_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      occ_q    <= occ_d;
      halted_q <= halted_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int k = 0; k < int'(NUM_IN); k++) begin
        if (in_valid_i[k]) mem_q[tail_q + PtrW'(k)] <= lane_ent[k];
      end
    end
  end

  assign halted_o    = halted_q;
  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_pipe_wb_multi.sv
// Randomised scoreboard bench for pipe_wb_multi against a queue-level reference model.
module tb_pipe_wb_multi;

  localparam int NI = 3;
  localparam int NW = 2;
  localparam int D  = 4;
  localparam int XL = 32;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic [NI-1:0]          in_valid;
  logic                   in_ready;
  logic [NI-1:0][XL-1:0]  in_pc, in_alu, in_lsu;
  logic [NI-1:0][31:0]    in_inst;
  logic [NI-1:0]          in_wen, in_ld, in_eb;
  logic [NI-1:0][4:0]     in_rd;
  logic [NW-1:0]          wb_wen, commit_valid;
  logic [NW-1:0][4:0]     wb_rd;
  logic [NW-1:0][XL-1:0]  wb_wdata, commit_pc;
  logic [NW-1:0][31:0]    commit_inst;
  logic [1:0][4:0]        fwd_rd;
  logic [1:0]             fwd_hit;
  logic [1:0][XL-1:0]     fwd_data;
  logic                   halted;
  logic [$clog2(D):0]     occupancy;

  pipe_wb_multi #(.NUM_IN(NI), .NUM_WP(NW), .DEPTH(D), .XLEN(XL)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_pc_i(in_pc), .in_inst_i(in_inst), .in_rd_wen_i(in_wen), .in_rd_i(in_rd),
    .in_is_load_i(in_ld), .in_alu_res_i(in_alu), .in_lsu_res_i(in_lsu), .in_ebreak_i(in_eb),
    .wb_wen_o(wb_wen), .wb_rd_o(wb_rd), .wb_wdata_o(wb_wdata), .commit_valid_o(commit_valid),
    .commit_pc_o(commit_pc), .commit_inst_o(commit_inst), .fwd_rd_i(fwd_rd),
    .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data), .halted_o(halted), .occupancy_o(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XL-1:0] pc;
    logic [31:0]   inst;
    bit            wen;
    logic [4:0]    rd;
    logic [XL-1:0] data;
    bit            eb;
  } ent_t;

  ent_t          mq[$];     // model of buffered entries, oldest first
  ent_t          exp_q[$];  // scoreboard of expected commits
  bit            halt_m = 1'b0;
  bit            fwd_rand = 1'b1;
  int            errs = 0;
  int            checks = 0;
  logic [XL-1:0] pc_ctr = 32'h1000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got 0x%0h want 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic set_lane(input int k, input logic [4:0] rd, input bit wen, input bit ld,
                          input logic [XL-1:0] alu, input logic [XL-1:0] lsu, input bit eb);
    in_pc[k]   = pc_ctr;
    pc_ctr     = pc_ctr + 4;
    in_inst[k] = $urandom;
    in_rd[k]   = rd;
    in_wen[k]  = wen;
    in_ld[k]   = ld;
    in_alu[k]  = alu;
    in_lsu[k]  = lsu;
    in_eb[k]   = eb;
  endtask

  // One clock: advance the reference model on the edge, then update lookup inputs.
  task automatic tick(output bit acc);
    bit flush;
    int n;
    ent_t e;
    @(posedge clk);
    acc   = 1'b0;
    flush = 1'b0;
    if (rst_i) begin
      acc = !halt_m && (D - mq.size() >= NI) && in_valid[0];
      n   = (mq.size() < NW) ? mq.size() : NW;
      for (int j = 0; j < n; j++) begin
        e = mq.pop_front();
        if (e.eb) begin
          flush = 1'b1;
          break;
        end
      end
      if (flush) begin
        mq.delete();
        halt_m = 1'b1;
      end else if (acc) begin
        for (int k = 0; k < NI; k++) begin
          if (in_valid[k]) begin
            e.pc   = in_pc[k];
            e.inst = in_inst[k];
            e.wen  = in_wen[k];
            e.rd   = in_rd[k];
            e.data = in_ld[k] ? in_lsu[k] : in_alu[k];
            e.eb   = in_eb[k];
            mq.push_back(e);
            exp_q.push_back(e);
          end
        end
      end
    end
    #1;
    if (fwd_rand) begin
      fwd_rd[0] = 5'($urandom_range(0, 7));
      fwd_rd[1] = 5'($urandom_range(0, 7));
    end
  endtask

  task automatic send();
    bit acc;
    acc = 1'b0;
    for (int b = 0; b < 20; b++) begin
      tick(acc);
      if (acc || halt_m) break;
    end
    chk("bundle_accepted", 64'(acc || halt_m), 64'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = '0;
    repeat (n) tick(acc);
  endtask

  task automatic rand_bundle(input int eb_rate, input int nv);
    in_valid = '0;
    for (int k = 0; k < NI; k++) begin
      set_lane(k, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
               $urandom_range(0, 1) == 1, $urandom, $urandom,
               eb_rate > 0 && $urandom_range(0, eb_rate - 1) == 0);
      if (k < nv) in_valid[k] = 1'b1;
    end
  endtask

  task automatic reset_dut();
    in_valid = '0;
    rst_i    = 1'b0;
    #1;
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_wb_wen", 64'(wb_wen), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    mq.delete();
    exp_q.delete();
    halt_m = 1'b0;
    @(posedge clk);
    #1 rst_i = 1'b1;
  endtask

  // Monitor: sampled mid-cycle, pops expected commits for every valid port.
  always @(negedge clk) begin
    int   n, exp_n, lim;
    bit   hit;
    logic [XL-1:0] d;
    ent_t e;
    if (rst_i) begin
      chk("occupancy", 64'(occupancy), 64'(mq.size()));
      chk("in_ready", 64'(in_ready), 64'(!halt_m && (D - mq.size() >= NI)));
      chk("halted", 64'(halted), 64'(halt_m));
      exp_n = 0;
      lim   = (mq.size() < NW) ? mq.size() : NW;
      for (int j = 0; j < lim; j++) begin
        exp_n++;
        if (mq[j].eb) break;
      end
      n = 0;
      for (int j = 0; j < NW; j++) begin
        if (commit_valid[j]) begin
          n++;
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("commit_pc", 64'(commit_pc[j]), 64'(e.pc));
            chk("commit_inst", 64'(commit_inst[j]), 64'(e.inst));
            chk("wb_rd", 64'(wb_rd[j]), 64'(e.rd));
            chk("wb_wdata", 64'(wb_wdata[j]), 64'(e.data));
            chk("wb_wen", 64'(wb_wen[j]), 64'(e.wen && e.rd != 5'd0));
            if (e.eb) exp_q.delete();
          end
        end else begin
          chk("wb_wen_idle", 64'(wb_wen[j]), 64'd0);
        end
      end
      chk("commit_count", 64'(n), 64'(exp_n));
      for (int p = 0; p < 2; p++) begin
        hit = 1'b0;
        d   = '0;
        foreach (mq[i]) begin
          if (mq[i].wen && mq[i].rd == fwd_rd[p] && mq[i].rd != 5'd0) begin
            hit = 1'b1;
            d   = mq[i].data;
          end
        end
        chk("fwd_hit", 64'(fwd_hit[p]), 64'(hit));
        chk("fwd_data", 64'(fwd_data[p]), 64'(d));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    in_valid = '0;
    in_pc = '0; in_alu = '0; in_lsu = '0; in_inst = '0;
    in_wen = '0; in_ld = '0; in_eb = '0; in_rd = '0;
    fwd_rd = '0;
    repeat (2) @(posedge clk);
    reset_dut();

    // Two-lane bundle: ALU result to x5, load result to x6.
    set_lane(0, 5'd5, 1'b1, 1'b0, 32'h11, 32'hdead, 1'b0);
    set_lane(1, 5'd6, 1'b1, 1'b1, 32'hbeef, 32'h22, 1'b0);
    set_lane(2, 5'd9, 1'b1, 1'b0, 32'h99, 32'h99, 1'b0);
    in_valid = 3'b011;
    send();
    idle(2);

    // Same rd twice plus an rd=0 writer; lookups on x7 and x0.
    fwd_rand  = 1'b0;
    fwd_rd[0] = 5'd7;
    fwd_rd[1] = 5'd0;
    set_lane(0, 5'd7, 1'b1, 1'b0, 32'hA, 32'h0, 1'b0);
    set_lane(1, 5'd7, 1'b1, 1'b1, 32'h0, 32'hB, 1'b0);
    set_lane(2, 5'd0, 1'b1, 1'b0, 32'h5, 32'h0, 1'b0);
    in_valid = 3'b111;
    send();
    idle(2);
    fwd_rand = 1'b1;

    // Back-to-back full bundles force stalls and pointer wrap.
    repeat (3) begin
      rand_bundle(0, NI);
      send();
    end
    idle(3);

    // Reset with three entries buffered.
    rand_bundle(0, NI);
    send();
    reset_dut();
    idle(1);

    // ebreak followed by a younger instruction in the same bundle.
    set_lane(0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    set_lane(1, 5'd1, 1'b1, 1'b0, 32'h7, 32'h0, 1'b0);
    set_lane(2, 5'd2, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    in_valid = 3'b011;
    send();
    rand_bundle(0, NI);
    repeat (4) tick(acc);
    idle(1);
    reset_dut();

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 120; i++) begin
        if (halt_m) break;
        if ($urandom_range(0, 4) == 0) idle(1);
        else begin
          rand_bundle((r >= 2) ? 40 : 0, $urandom_range(1, NI));
          send();
        end
      end
      idle(3);
      reset_dut();
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
